// File: rtl/seq_alu_acc_if.sv
// Operation request / result bus between the tile pins and the seq_alu_acc datapath.
interface seq_alu_acc_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             carry;
  logic             zero;

  modport master (
    output in_valid, op, a, b,
    input  in_ready, out_valid, result, result_hi, carry, zero
  );

  modport slave (
    input  in_valid, op, a, b,
    output in_ready, out_valid, result, result_hi, carry, zero
  );
endinterface

// File: rtl/seq_alu_acc.sv
// Registered multi-op ALU with an accumulator and an iterative shift-add multiplier.
// Single-cycle ops complete at the accept edge; MUL blocks new requests for WIDTH cycles.
module seq_alu_acc #(
  parameter int WIDTH = 8
) (
  input logic         clk,
  input logic         rst_n,
  seq_alu_acc_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_ACC = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_CLR = 3'b111;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   result_q;
  logic [WIDTH-1:0]   result_hi_q;
  logic               carry_q;
  logic               zero_q;
  logic               out_valid_q;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] prod;
  logic [CNT_W-1:0]   count;

  logic [WIDTH:0]     sum_w;
  logic [WIDTH:0]     diff_w;
  logic [WIDTH:0]     acc_w;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_carry;
  logic [2*WIDTH-1:0] prod_next;

  always_comb begin
    sum_w     = {1'b0, bus.a} + {1'b0, bus.b};
    diff_w    = {1'b0, bus.a} - {1'b0, bus.b};
    acc_w     = {1'b0, acc} + {1'b0, bus.a};
    alu_res   = '0;
    alu_carry = 1'b0;
    case (bus.op)
      OP_ADD: begin
        alu_res   = sum_w[WIDTH-1:0];
        alu_carry = sum_w[WIDTH];
      end
      OP_SUB: begin
        alu_res   = diff_w[WIDTH-1:0];
        alu_carry = diff_w[WIDTH];
      end
      OP_AND: alu_res = bus.a & bus.b;
      OP_OR:  alu_res = bus.a | bus.b;
      OP_XOR: alu_res = bus.a ^ bus.b;
      OP_ACC: begin
        alu_res   = acc_w[WIDTH-1:0];
        alu_carry = acc_w[WIDTH];
      end
      default: begin
        alu_res   = '0;
        alu_carry = 1'b0;
      end
    endcase
  end

  // One shift-add step: multiplier consumed LSB-first, multiplicand shifts left.
  always_comb begin
    prod_next = prod + (mplier[0] ? mcand : '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      acc         <= '0;
      result_q    <= '0;
      result_hi_q <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
      mplier      <= '0;
      mcand       <= '0;
      prod        <= '0;
      count       <= '0;
    end else begin
      out_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            if (bus.op == OP_MUL) begin
              state  <= MUL;
              mcand  <= {{WIDTH{1'b0}}, bus.a};
              mplier <= bus.b;
              prod   <= '0;
              count  <= CNT_W'(WIDTH);
            end else begin
              result_q    <= alu_res;
              result_hi_q <= '0;
              carry_q     <= alu_carry;
              zero_q      <= (alu_res == '0);
              out_valid_q <= 1'b1;
              if (bus.op == OP_ACC) begin
                acc <= acc_w[WIDTH-1:0];
              end else if (bus.op == OP_CLR) begin
                acc <= '0;
              end
            end
          end
        end
        MUL: begin
          prod   <= prod_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count - CNT_W'(1);
          // Last iteration publishes the completed product directly from prod_next.
          if (count == CNT_W'(1)) begin
            result_q    <= prod_next[WIDTH-1:0];
            result_hi_q <= prod_next[2*WIDTH-1:WIDTH];
            carry_q     <= 1'b0;
            zero_q      <= (prod_next == '0);
            out_valid_q <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.result_hi = result_hi_q;
  assign bus.carry     = carry_q;
  assign bus.zero      = zero_q;
endmodule

// File: tb/tb_seq_alu_acc.sv
// Self-checking bench for seq_alu_acc: scoreboard fed at accept, drained at out_valid,
// plus per-scenario cycle-exact checks.
module tb_seq_alu_acc;
  localparam int W = 8;

  localparam logic [2:0] ADD = 3'd0;
  localparam logic [2:0] SUB = 3'd1;
  localparam logic [2:0] AND = 3'd2;
  localparam logic [2:0] OR  = 3'd3;
  localparam logic [2:0] XOR = 3'd4;
  localparam logic [2:0] ACC = 3'd5;
  localparam logic [2:0] MUL = 3'd6;
  localparam logic [2:0] CLR = 3'd7;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  seq_alu_acc_if #(.WIDTH(W)) bus ();
  seq_alu_acc #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct packed {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         c;
    logic         z;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] m_acc;
  int           n_cmp = 0;
  int           n_bad = 0;
  int           ov_count = 0;

  // Scoreboard: results are compared before the same-edge accept is modelled.
  always @(negedge clk) begin
    exp_t         e;
    exp_t         g;
    logic [W:0]   t;
    logic [2*W-1:0] p;
    if (rst_n) begin
      if (bus.out_valid) begin
        ov_count++;
        n_cmp++;
        g = {bus.result, bus.result_hi, bus.carry, bus.zero};
        if (sb.size() == 0) begin
          n_bad++;
          $display("[TB] FAIL sb_unexpected: got out_valid=1 result=%0h, required no pending result", bus.result);
        end else begin
          e = sb.pop_front();
          if (g !== e) begin
            n_bad++;
            $display("[TB] FAIL sb_result: got res=%0h hi=%0h c=%0b z=%0b, required res=%0h hi=%0h c=%0b z=%0b",
                     g.res, g.hi, g.c, g.z, e.res, e.hi, e.c, e.z);
          end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        e = '0;
        p = '0;
        case (bus.op)
          ADD: begin
            t = {1'b0, bus.a} + {1'b0, bus.b};
            e.res = t[W-1:0];
            e.c = t[W];
          end
          SUB: begin
            e.res = bus.a - bus.b;
            e.c = (bus.a < bus.b);
          end
          AND: e.res = bus.a & bus.b;
          OR:  e.res = bus.a | bus.b;
          XOR: e.res = bus.a ^ bus.b;
          ACC: begin
            t = {1'b0, m_acc} + {1'b0, bus.a};
            m_acc = t[W-1:0];
            e.res = m_acc;
            e.c = t[W];
          end
          MUL: begin
            p = (2*W)'(bus.a) * (2*W)'(bus.b);
            e.res = p[W-1:0];
            e.hi = p[2*W-1:W];
          end
          default: begin
            m_acc = '0;
            e.res = '0;
          end
        endcase
        e.z = (bus.op == MUL) ? (p == '0) : (e.res == '0);
        sb.push_back(e);
      end
    end
  end

  task test_reset;
    #1;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.op = ADD;
    bus.a = '0;
    bus.b = '0;
    sb.delete();
    m_acc = '0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_out_valid: got %0b required 0", bus.out_valid); end
    n_cmp++; if (bus.result !== '0) begin n_bad++; $display("[TB] FAIL reset_result: got %0h required 0", bus.result); end
    n_cmp++; if (bus.result_hi !== '0) begin n_bad++; $display("[TB] FAIL reset_result_hi: got %0h required 0", bus.result_hi); end
    n_cmp++; if (bus.carry !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_carry: got %0b required 0", bus.carry); end
    n_cmp++; if (bus.zero !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_zero: got %0b required 0", bus.zero); end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL reset_in_ready: got %0b required 1", bus.in_ready); end
  endtask

  task test_add;
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.op = ADD; bus.a = 8'd200; bus.b = 8'd100;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL add_out_valid: got %0b required 1", bus.out_valid); end
    n_cmp++; if (bus.result !== 8'd44) begin n_bad++; $display("[TB] FAIL add_result: got %0d required 44", bus.result); end
    n_cmp++; if (bus.carry !== 1'b1) begin n_bad++; $display("[TB] FAIL add_carry: got %0b required 1", bus.carry); end
    n_cmp++; if (bus.zero !== 1'b0 || bus.result_hi !== '0) begin n_bad++; $display("[TB] FAIL add_zero_hi: got z=%0b hi=%0h required z=0 hi=0", bus.zero, bus.result_hi); end
    @(negedge clk);
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL add_pulse: got out_valid=%0b required 0", bus.out_valid); end
    n_cmp++; if (bus.result !== 8'd44) begin n_bad++; $display("[TB] FAIL add_hold: got %0d required 44", bus.result); end
  endtask

  task test_sub;
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.op = SUB; bus.a = 8'd5; bus.b = 8'd7;
    @(posedge clk); #1;
    bus.a = 8'd7;
    @(negedge clk);
    n_cmp++; if (bus.result !== 8'd254 || bus.carry !== 1'b1) begin n_bad++; $display("[TB] FAIL sub_borrow: got res=%0d c=%0b required res=254 c=1", bus.result, bus.carry); end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL sub_b2b_valid: got %0b required 1", bus.out_valid); end
    n_cmp++; if (bus.result !== '0 || bus.zero !== 1'b1 || bus.carry !== 1'b0) begin n_bad++; $display("[TB] FAIL sub_zero: got res=%0d z=%0b c=%0b required res=0 z=1 c=0", bus.result, bus.zero, bus.carry); end
  endtask

  task test_acc_chain;
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.op = CLR; bus.a = 8'd0; bus.b = 8'd0;
    @(posedge clk); #1;
    bus.op = ACC; bus.a = 8'd100;
    @(negedge clk);
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.result !== 8'd0) begin n_bad++; $display("[TB] FAIL acc_clr: got ov=%0b res=%0d required ov=1 res=0", bus.out_valid, bus.result); end
    @(posedge clk); #1;
    bus.a = 8'd200;
    @(negedge clk);
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.result !== 8'd100) begin n_bad++; $display("[TB] FAIL acc_100: got ov=%0b res=%0d required ov=1 res=100", bus.out_valid, bus.result); end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.result !== 8'd44 || bus.carry !== 1'b1) begin n_bad++; $display("[TB] FAIL acc_wrap: got ov=%0b res=%0d c=%0b required ov=1 res=44 c=1", bus.out_valid, bus.result, bus.carry); end
    @(negedge clk);
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL acc_pulse: got %0b required 0", bus.out_valid); end
  endtask

  task test_mul;
    bit got;
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.op = MUL; bus.a = 8'd255; bus.b = 8'd255;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    for (int i = 1; i <= W; i++) begin
      @(negedge clk);
      n_cmp++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL mul_busy_k%0d: got rdy=%0b ov=%0b required rdy=0 ov=0", i, bus.in_ready, bus.out_valid); end
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL mul_done: got ov=%0b rdy=%0b required ov=1 rdy=1", bus.out_valid, bus.in_ready); end
    n_cmp++; if (bus.result !== 8'h01 || bus.result_hi !== 8'hFE || bus.zero !== 1'b0) begin n_bad++; $display("[TB] FAIL mul_ff: got hi=%0h lo=%0h z=%0b required hi=fe lo=01 z=0", bus.result_hi, bus.result, bus.zero); end
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.op = MUL; bus.a = 8'd0; bus.b = 8'd9;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (bus.out_valid) got = 1'b1;
    end
    n_cmp++;
    if (!got) begin
      n_bad++; $display("[TB] FAIL mul_zero_timeout: got no out_valid in 20 cycles required one");
    end else if (bus.zero !== 1'b1 || bus.result !== '0) begin
      n_bad++; $display("[TB] FAIL mul_zero: got z=%0b res=%0h required z=1 res=0", bus.zero, bus.result);
    end
  endtask

  task test_mul_stall;
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.op = MUL; bus.a = 8'd13; bus.b = 8'd11;
    @(posedge clk); #1;
    bus.op = ADD; bus.a = 8'd3; bus.b = 8'd4;
    for (int i = 1; i <= W; i++) begin
      @(negedge clk);
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL stall_k%0d: got ov=%0b required 0", i, bus.out_valid); end
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.result !== 8'd143 || bus.result_hi !== 8'd0) begin n_bad++; $display("[TB] FAIL stall_mul: got ov=%0b res=%0d hi=%0d required ov=1 res=143 hi=0", bus.out_valid, bus.result, bus.result_hi); end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.result !== 8'd7 || bus.result_hi !== 8'd0) begin n_bad++; $display("[TB] FAIL stall_add: got ov=%0b res=%0d hi=%0d required ov=1 res=7 hi=0", bus.out_valid, bus.result, bus.result_hi); end
    @(negedge clk);
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL stall_single: got ov=%0b required 0", bus.out_valid); end
  endtask

  task test_random;
    int  issued;
    int  cyc;
    bit  taken;
    issued = 0;
    cyc = 0;
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.op = 3'($urandom_range(0, 7)); bus.a = 8'($urandom); bus.b = 8'($urandom);
    while (issued < 24 && cyc < 1000) begin
      @(negedge clk);
      taken = bus.in_ready;
      @(posedge clk); #1;
      cyc++;
      if (taken) issued++;
      bus.op = 3'($urandom_range(0, 7)); bus.a = 8'($urandom); bus.b = 8'($urandom);
    end
    bus.in_valid = 1'b0;
    repeat (W + 4) @(negedge clk);
    n_cmp++; if (sb.size() != 0 || issued != 24) begin n_bad++; $display("[TB] FAIL random_drain: got pending=%0d issued=%0d required pending=0 issued=24", sb.size(), issued); end
  endtask

  task test_reset_mid_mul;
    int ov_before;
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.op = MUL; bus.a = 8'd255; bus.b = 8'd255;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    sb.delete();
    m_acc = '0;
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.result !== '0 || bus.result_hi !== '0) begin n_bad++; $display("[TB] FAIL rst_mid_data: got ov=%0b res=%0h hi=%0h required all 0", bus.out_valid, bus.result, bus.result_hi); end
    n_cmp++; if (bus.carry !== 1'b0 || bus.zero !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_mid_flags: got c=%0b z=%0b required 0 0", bus.carry, bus.zero); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL rst_mid_ready: got %0b required 1", bus.in_ready); end
    ov_before = ov_count;
    repeat (W + 4) @(negedge clk);
    n_cmp++; if (ov_count != ov_before) begin n_bad++; $display("[TB] FAIL rst_mid_no_output: got %0d pulses required 0", ov_count - ov_before); end
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.op = ACC; bus.a = 8'd3; bus.b = 8'd0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.result !== 8'd3 || bus.carry !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_mid_acc: got ov=%0b res=%0d c=%0b required ov=1 res=3 c=0", bus.out_valid, bus.result, bus.carry); end
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got simulation still running required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_acc_chain();
    test_mul();
    test_mul_stall();
    test_random();
    test_reset_mid_mul();
    repeat (2) @(negedge clk);
    n_cmp++; if (sb.size() != 0) begin n_bad++; $display("[TB] FAIL final_queue: got %0d pending required 0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
